// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: stall patterns,
// EX op classes, controller state codes and the op-length helper.
package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall vector bits: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  localparam logic [1:0] ExOpNone = 2'b00;
  localparam logic [1:0] ExOpMadd = 2'b01;
  localparam logic [1:0] ExOpDiv  = 2'b10;
  localparam logic [1:0] ExOpDivu = 2'b11;

  typedef enum logic [1:0] {
    CtrlIdle = 2'b00,
    CtrlRun  = 2'b01,
    CtrlDone = 2'b10
  } ctrl_state_e;

  // Initial remaining-cycle count for an op: its total length minus the start cycle
  function automatic logic [5:0] phase_init(input logic [1:0] op,
                                            input int unsigned madd_cycles,
                                            input int unsigned div_cycles);
    if (op == ExOpMadd) return 6'(madd_cycles - 1);
    else                return 6'(div_cycles - 1);
  endfunction

endpackage

// File: rtl/mc_timer.sv
// Loadable down-counter for multi-cycle EX ops. Cancel clears the count,
// load takes priority over decrement, and the count never wraps below zero.
module mc_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [5:0] i_load_val,
  input  logic       i_cancel,
  input  logic       i_dec,
  output logic [5:0] o_phase,
  output logic       o_zero
);

  logic [5:0] r_phase;

  // Remaining-cycle counter: cancel > load > decrement
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 6'd0;
    end else if (i_cancel) begin
      r_phase <= 6'd0;
    end else if (i_load) begin
      r_phase <= i_load_val;
    end else if (i_dec && (r_phase != 6'd0)) begin
      r_phase <= r_phase - 6'd1;
    end
  end

  assign o_phase = r_phase;
  assign o_zero  = (r_phase == 6'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: sequences multi-cycle EX ops (MADD/MSUB, DIV/DIVU)
// and merges them with ID load-use and MEM wait requests into the stall vector.
// Optional feature: define PIPE_CTRL_PERF_EN to build the stalled-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MADD_CYCLES = 2,
  parameter int unsigned DIV_CYCLES  = 33
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stallreq_id,
  input  logic        i_ex_start,
  input  logic [1:0]  i_ex_op,
  input  logic        i_ex_cancel,
  input  logic        i_mem_wait,
  output logic [5:0]  o_stall,
  output logic [5:0]  o_ex_phase,
  output logic        o_ex_done,
  output logic        o_busy,
  output logic [31:0] o_perf_stall_cnt
);

  ctrl_state_e r_state;
  logic        r_ex_done;
  logic        r_busy;

  logic        w_ex_valid;
  logic        w_idle;
  logic        w_run;
  logic        w_load;
  logic        w_cancel;
  logic        w_last;
  logic        w_zero;
  logic [5:0]  w_phase;
  logic [5:0]  w_load_val;
  logic [5:0]  w_stall;

  assign w_ex_valid = i_ex_start && (i_ex_op != ExOpNone);
  assign w_idle     = (r_state == CtrlIdle);
  assign w_run      = (r_state == CtrlRun);
  assign w_load     = w_idle && w_ex_valid;
  assign w_cancel   = w_run && i_ex_cancel;
  assign w_load_val = phase_init(i_ex_op, MADD_CYCLES, DIV_CYCLES);
  // Zero also ends RUN so a one-cycle op cannot get stuck
  assign w_last     = (w_phase == 6'd1) || w_zero;

  mc_timer u_mc_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_cancel   (w_cancel),
    .i_dec      (w_run),
    .o_phase    (w_phase),
    .o_zero     (w_zero)
  );

  // Controller FSM with registered ex_done/busy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= CtrlIdle;
      r_ex_done <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        CtrlIdle: begin
          if (w_ex_valid) begin
            r_state <= CtrlRun;
            r_busy  <= 1'b1;
          end
        end
        CtrlRun: begin
          if (i_ex_cancel || w_last) begin
            r_state   <= CtrlDone;
            r_ex_done <= 1'b1;
          end
        end
        CtrlDone: begin
          // Result stays valid until MEM can accept it
          if (!i_mem_wait) begin
            r_state   <= CtrlIdle;
            r_ex_done <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state   <= CtrlIdle;
          r_ex_done <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Stall merge, highest priority first: MEM wait, EX op, ID load-use
  always_comb begin
    w_stall = StallNone;
    if (i_mem_wait) begin
      w_stall = StallMem;
    end else if (w_load || w_run) begin
      w_stall = StallEx;
    end else if (i_stallreq_id) begin
      w_stall = StallId;
    end
  end

  // WB stall is owned by the exception unit
  assign o_stall    = {NoStop, w_stall[4:0]};
  assign o_ex_phase = w_phase;
  assign o_ex_done  = r_ex_done;
  assign o_busy     = r_busy;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_cnt;

  // Count every edge on which the PC is held
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_cnt <= 32'd0;
    end else if (w_stall[0] == Stop) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_cnt;
`else
  assign o_perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stallreq_id;
  logic        i_ex_start;
  logic [1:0]  i_ex_op;
  logic        i_ex_cancel;
  logic        i_mem_wait;
  logic [5:0]  o_stall;
  logic [5:0]  o_ex_phase;
  logic        o_ex_done;
  logic        o_busy;
  logic [31:0] o_perf_stall_cnt;

  int checks;
  int failures;

  pipe_ctrl #(
    .MADD_CYCLES (2),
    .DIV_CYCLES  (33)
  ) u_dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_stallreq_id    (i_stallreq_id),
    .i_ex_start       (i_ex_start),
    .i_ex_op          (i_ex_op),
    .i_ex_cancel      (i_ex_cancel),
    .i_mem_wait       (i_mem_wait),
    .o_stall          (o_stall),
    .o_ex_phase       (o_ex_phase),
    .o_ex_done        (o_ex_done),
    .o_busy           (o_busy),
    .o_perf_stall_cnt (o_perf_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_stallreq_id = 1'b0;
    i_ex_start    = 1'b0;
    i_ex_op       = 2'b00;
    i_ex_cancel   = 1'b0;
    i_mem_wait    = 1'b0;
  endtask

  logic saw_done;
  logic [31:0] perf_exp;

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    i_rst_n = 1'b0;
    #12;
    check("rst_stall", 32'(o_stall), 32'h00);
    check("rst_phase", 32'(o_ex_phase), 32'd0);
    check("rst_done", 32'(o_ex_done), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_perf", o_perf_stall_cnt, 32'd0);
    step();
    i_rst_n = 1'b1;
    step();

    // MADD: two stall cycles then a one-cycle done
    i_ex_start = 1'b1; i_ex_op = 2'b01; #1;
    check("madd_c1_stall", 32'(o_stall), 32'h0f);
    check("madd_c1_busy", 32'(o_busy), 32'd0);
    step(); idle_inputs(); #1;
    check("madd_c2_stall", 32'(o_stall), 32'h0f);
    check("madd_c2_phase", 32'(o_ex_phase), 32'd1);
    check("madd_c2_busy", 32'(o_busy), 32'd1);
    step();
    check("madd_c3_done", 32'(o_ex_done), 32'd1);
    check("madd_c3_stall", 32'(o_stall), 32'h00);
    step();
    check("madd_c4_done", 32'(o_ex_done), 32'd0);
    check("madd_c4_busy", 32'(o_busy), 32'd0);

    // DIV: 33 stall cycles, done in cycle 34, restart in cycle 5 ignored
    i_ex_start = 1'b1; i_ex_op = 2'b10; #1;
    check("div_c1_stall", 32'(o_stall), 32'h0f);
    step(); idle_inputs();
    for (int c = 2; c <= 33; c++) begin
      if (c == 5) begin
        i_ex_start = 1'b1; i_ex_op = 2'b01;
      end else begin
        i_ex_start = 1'b0; i_ex_op = 2'b00;
      end
      #1;
      check($sformatf("div_c%0d_stall", c), 32'(o_stall), 32'h0f);
      check($sformatf("div_c%0d_phase", c), 32'(o_ex_phase), 32'(34 - c));
      check($sformatf("div_c%0d_done", c), 32'(o_ex_done), 32'd0);
      step();
    end
    idle_inputs();
    check("div_c34_done", 32'(o_ex_done), 32'd1);
    check("div_c34_stall", 32'(o_stall), 32'h00);
    step();
    check("div_c35_done", 32'(o_ex_done), 32'd0);
    check("div_c35_busy", 32'(o_busy), 32'd0);

    // DIVU cancelled in RUN cycle 3
    i_ex_start = 1'b1; i_ex_op = 2'b11;
    step(); idle_inputs();
    step();
    check("cancel_r2_phase", 32'(o_ex_phase), 32'd31);
    step();
    i_ex_cancel = 1'b1; #1;
    check("cancel_r3_stall", 32'(o_stall), 32'h0f);
    step(); idle_inputs(); #1;
    check("cancel_done", 32'(o_ex_done), 32'd1);
    check("cancel_stall", 32'(o_stall), 32'h00);
    check("cancel_phase", 32'(o_ex_phase), 32'd0);
    step();
    check("cancel_idle_busy", 32'(o_busy), 32'd0);

    // mem_wait over the end of a MADD
    i_ex_start = 1'b1; i_ex_op = 2'b01;
    step(); idle_inputs();
    i_mem_wait = 1'b1; #1;
    check("mw_run_stall", 32'(o_stall), 32'h1f);
    step();
    check("mw_d1_stall", 32'(o_stall), 32'h1f);
    check("mw_d1_done", 32'(o_ex_done), 32'd1);
    step();
    check("mw_d2_stall", 32'(o_stall), 32'h1f);
    check("mw_d2_done", 32'(o_ex_done), 32'd1);
    step();
    i_mem_wait = 1'b0; #1;
    check("mw_fall_done", 32'(o_ex_done), 32'd1);
    check("mw_fall_stall", 32'(o_stall), 32'h00);
    step();
    check("mw_after_done", 32'(o_ex_done), 32'd0);
    check("mw_after_busy", 32'(o_busy), 32'd0);

    // Stall merge priority and the ignored no-op start
    i_stallreq_id = 1'b1; #1;
    check("id_only", 32'(o_stall), 32'h07);
    i_mem_wait = 1'b1; #1;
    check("id_and_mem", 32'(o_stall), 32'h1f);
    i_mem_wait = 1'b0; i_ex_start = 1'b1; i_ex_op = 2'b10; #1;
    check("id_and_ex", 32'(o_stall), 32'h0f);
    idle_inputs(); i_ex_start = 1'b1; i_ex_op = 2'b00; #1;
    check("nop_start_stall", 32'(o_stall), 32'h00);
    step(); idle_inputs();
    check("nop_start_busy", 32'(o_busy), 32'd0);

    // Asynchronous reset mid-RUN at ex_phase 20
    i_ex_start = 1'b1; i_ex_op = 2'b10;
    step(); idle_inputs();
    for (int i = 0; i < 12; i++) step();
    check("pre_rst_phase", 32'(o_ex_phase), 32'd20);
    #2;
    i_rst_n = 1'b0; #1;
    check("mid_rst_stall", 32'(o_stall), 32'h00);
    check("mid_rst_phase", 32'(o_ex_phase), 32'd0);
    check("mid_rst_done", 32'(o_ex_done), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_perf", o_perf_stall_cnt, 32'd0);
    step();
    i_rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_ex_done) saw_done = 1'b1;
    end
    check("no_done_after_rst", 32'(saw_done), 32'd0);

    // Ten stalled edges for the performance counter
    i_stallreq_id = 1'b1;
    for (int i = 0; i < 10; i++) step();
    i_stallreq_id = 1'b0; #1;
`ifdef PIPE_CTRL_PERF_EN
    perf_exp = 32'd10;
`else
    perf_exp = 32'd0;
`endif
    check("perf_cnt", o_perf_stall_cnt, perf_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
